timer_period_ctrl: RTL and testbench

//  Timer/period control stage that drives the TMR/PR magnitude comparator and consumes its match result.

---
 rtl/timer_period_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_timer_period_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_period_ctrl.sv
// ---------------------------------------------------------------------------
// timer_period_ctrl
//
// Timer/period control stage sitting in front of an external TMR/PR magnitude
// comparator. It owns the 16-bit timer count, the period register and the
// control register, and turns the comparator's match result into a timer
// reload, a one-cycle match pulse and a postscaled sticky interrupt flag.
// Software reaches all of it through a small write port and a combinational
// read mux.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   wr_en        single-cycle register write strobe
//   wr_addr      write target: 0=TMR 1=PR 2=CON 3=FLAG_CLR
//   wr_data      write data
//   rd_addr      read select, same map (3 returns the flag in bit 0)
//   rd_data      combinational readback of the selected register
//   match_in     comparator result (tmr == pr), fed back from tmr/pr
//   tmr          current timer count, to the comparator
//   pr           period register, to the comparator
//   match_pulse  one-cycle pulse after a tick that saw match_in high
//   tmr_if       sticky interrupt flag, set once every (post_sel+1) matches
//
// CON layout
//   bit 0      ton        timer enable
//   bits 2:1   presc_sel  00=1:1 01=1:4 10=1:16 11=1:16
//   bits 6:3   post_sel   n selects a 1:(n+1) postscaler
// ---------------------------------------------------------------------------
module timer_period_ctrl #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] PR_RST = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             match_in,
  output logic [WIDTH-1:0] tmr,
  output logic [WIDTH-1:0] pr,
  output logic             match_pulse,
  output logic             tmr_if
);

  localparam logic [1:0] ADDR_TMR  = 2'd0;
  localparam logic [1:0] ADDR_PR   = 2'd1;
  localparam logic [1:0] ADDR_CON  = 2'd2;
  localparam logic [1:0] ADDR_FLAG = 2'd3;

  logic [6:0] con;
  logic [3:0] presc_cnt;
  logic [3:0] post_cnt;
  logic [3:0] presc_max;

  logic       ton;
  logic [1:0] presc_sel;
  logic [3:0] post_sel;

  logic       tmr_wr;
  logic       pr_wr;
  logic       con_wr;
  logic       flag_clr;
  logic       tick;
  logic       tick_eff;
  logic       match_tick;
  logic       post_wrap;
  logic       flag_set;

  assign ton       = con[0];
  assign presc_sel = con[2:1];
  assign post_sel  = con[6:3];

  assign tmr_wr   = wr_en && (wr_addr == ADDR_TMR);
  assign pr_wr    = wr_en && (wr_addr == ADDR_PR);
  assign con_wr   = wr_en && (wr_addr == ADDR_CON);
  assign flag_clr = wr_en && (wr_addr == ADDR_FLAG) && wr_data[0];

  // Terminal count of the prescaler for the selected division ratio. Both
  // 1:16 encodings share one terminal value.
  always_comb begin
    presc_max = 4'd15;
    case (presc_sel)
      2'b00:   presc_max = 4'd0;
      2'b01:   presc_max = 4'd3;
      default: presc_max = 4'd15;
    endcase
  end

  // A tick is the prescaler reaching its terminal count while running.
  // Writes to TMR or CON restart the prescaler/postscaler and therefore
  // swallow any tick landing on the same edge; a PR write does not, so that
  // tick still acts on the comparator result of the old period.
  assign tick       = ton && (presc_cnt == presc_max);
  assign tick_eff   = tick && !tmr_wr && !con_wr;
  assign match_tick = tick_eff && match_in;
  assign post_wrap  = (post_cnt == post_sel);
  assign flag_set   = match_tick && post_wrap;

  // Prescaler: free-runs while enabled, wraps on the tick, holds when the
  // timer is off, and restarts on any TMR or CON write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= 4'd0;
    end else if (tmr_wr || con_wr) begin
      presc_cnt <= 4'd0;
    end else if (ton) begin
      if (tick) begin
        presc_cnt <= 4'd0;
      end else begin
        presc_cnt <= presc_cnt + 4'd1;
      end
    end
  end

  // Timer count: a software write has priority; otherwise each tick either
  // reloads to zero on a period match or advances by one. Counting past the
  // all-ones value simply wraps, so a count that starts above the period
  // travels through zero before it can meet the period again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (tmr_wr) begin
      tmr <= wr_data;
    end else if (tick_eff) begin
      if (match_in) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Period and control registers are plain software-written storage. Only the
  // low seven CON bits exist; the rest read back as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pr  <= PR_RST;
      con <= 7'd0;
    end else begin
      if (pr_wr) begin
        pr <= wr_data;
      end
      if (con_wr) begin
        con <= wr_data[6:0];
      end
    end
  end

  // Postscaler: counts period matches and wraps when it reaches post_sel,
  // which is the same edge that raises the interrupt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_cnt <= 4'd0;
    end else if (tmr_wr || con_wr) begin
      post_cnt <= 4'd0;
    end else if (match_tick) begin
      if (post_wrap) begin
        post_cnt <= 4'd0;
      end else begin
        post_cnt <= post_cnt + 4'd1;
      end
    end
  end

  // Match pulse and sticky flag are registered so they appear together with
  // the timer reload. A flag set beats a same-edge software clear so that an
  // interrupt can never be lost to a racing acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_pulse <= 1'b0;
      tmr_if      <= 1'b0;
    end else begin
      match_pulse <= match_tick;
      if (flag_set) begin
        tmr_if <= 1'b1;
      end else if (flag_clr) begin
        tmr_if <= 1'b0;
      end
    end
  end

  // Combinational readback mux.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      ADDR_TMR: rd_data = tmr;
      ADDR_PR:  rd_data = pr;
      ADDR_CON: rd_data = {{(WIDTH-7){1'b0}}, con};
      default:  rd_data = {{(WIDTH-1){1'b0}}, tmr_if};
    endcase
  end

endmodule

// File: tb/tb_timer_period_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_period_ctrl
//
// Drives timer_period_ctrl with directed scenarios followed by randomized
// register traffic. The comparator is modelled here as (tmr == pr). A
// behavioural model tracks the timer as plain integers: prescaler phase taken
// modulo the division ratio and matches counted since the last restart, with
// the flag raised whenever that count is a multiple of the postscale ratio.
// ---------------------------------------------------------------------------
module tb_timer_period_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = 2'd0;
  logic [15:0] wr_data = 16'd0;
  logic [1:0]  rd_addr = 2'd0;
  logic [15:0] rd_data;
  logic        match_in;
  logic [15:0] tmr;
  logic [15:0] pr;
  logic        match_pulse;
  logic        tmr_if;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  int m_tmr;
  int m_pr;
  int m_con;
  int m_phase;
  int m_matches;
  bit m_pulse;
  bit m_if;

  logic [15:0] exp_t2 [6] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
  logic [15:0] exp_t3 [9] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0};
  logic [15:0] exp_t5 [7] = '{16'hFFFE, 16'hFFFF, 16'd0, 16'd1, 16'd2, 16'd3, 16'd0};

  logic        r_we;
  logic [1:0]  r_addr;
  logic [15:0] r_data;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Stand-in for the magnitude comparator that closes the loop.
  assign match_in = (tmr == pr);

  timer_period_ctrl #(
    .WIDTH (16),
    .PR_RST(16'hFFFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .match_in   (match_in),
    .tmr        (tmr),
    .pr         (pr),
    .match_pulse(match_pulse),
    .tmr_if     (tmr_if)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model state after reset.
  task automatic modelReset();
    m_tmr     = 0;
    m_pr      = 65535;
    m_con     = 0;
    m_phase   = 0;
    m_matches = 0;
    m_pulse   = 1'b0;
    m_if      = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic modelStep();
    int div;
    int post;
    bit ton;
    bit match;
    bit tick;
    bit tick_eff;
    bit tmrw;
    bit conw;
    bit set;
    ton = m_con[0];
    case ((m_con >> 1) & 3)
      0:       div = 1;
      1:       div = 4;
      default: div = 16;
    endcase
    post  = (m_con >> 3) & 15;
    match = (m_tmr == m_pr);
    tmrw  = wr_en && (wr_addr == 2'd0);
    conw  = wr_en && (wr_addr == 2'd2);
    tick  = 1'b0;
    if (ton) begin
      m_phase = (m_phase + 1) % div;
      tick    = (m_phase == 0);
    end
    tick_eff = tick && !tmrw && !conw;
    set      = 1'b0;
    m_pulse  = tick_eff && match;
    if (tick_eff) begin
      if (match) begin
        m_tmr = 0;
        m_matches++;
        set = ((m_matches % (post + 1)) == 0);
      end else begin
        m_tmr = (m_tmr + 1) % 65536;
      end
    end
    if (wr_en) begin
      case (wr_addr)
        2'd0: begin
          m_tmr     = int'(wr_data);
          m_phase   = 0;
          m_matches = 0;
        end
        2'd1: m_pr = int'(wr_data);
        2'd2: begin
          m_con     = int'(wr_data) & 127;
          m_phase   = 0;
          m_matches = 0;
        end
        default: if (wr_data[0]) m_if = 1'b0;
      endcase
    end
    if (set) m_if = 1'b1;
  endtask

  // Compare every observable output against the model.
  task automatic checkOutput();
    logic [15:0] exp_rd;
    case (rd_addr)
      2'd0:    exp_rd = 16'(m_tmr);
      2'd1:    exp_rd = 16'(m_pr);
      2'd2:    exp_rd = 16'(m_con);
      default: exp_rd = {15'd0, m_if};
    endcase
    check("tmr", tmr, 16'(m_tmr));
    check("pr", pr, 16'(m_pr));
    check("match_pulse", {15'd0, match_pulse}, {15'd0, m_pulse});
    check("tmr_if", {15'd0, tmr_if}, {15'd0, m_if});
    check("rd_data", rd_data, exp_rd);
  endtask

  // One clock of stimulus: drive on the falling edge, step the model on the
  // rising edge, compare shortly after it.
  task automatic applyStimulus(input logic we, input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    rd_addr = 2'($urandom_range(0, 3));
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  initial begin
    // Power-on reset.
    modelReset();
    rd_addr = 2'd2;
    #12;
    check("por_tmr", tmr, 16'd0);
    check("por_pr", pr, 16'hFFFF);
    check("por_if", {15'd0, tmr_if}, 16'd0);
    check("por_pulse", {15'd0, match_pulse}, 16'd0);
    check("por_con", rd_data, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running 1:1 count with period 3.
    applyStimulus(1'b1, 2'd1, 16'd3);
    applyStimulus(1'b1, 2'd0, 16'd0);
    applyStimulus(1'b1, 2'd2, 16'h0001);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) applyStimulus(1'b0, 2'd0, 16'd0);
      check($sformatf("t2_tmr%0d", i), tmr, exp_t2[i]);
      check($sformatf("t2_pulse%0d", i), {15'd0, match_pulse}, (i == 4) ? 16'd1 : 16'd0);
      check($sformatf("t2_if%0d", i), {15'd0, tmr_if}, (i >= 4) ? 16'd1 : 16'd0);
    end

    // 1:4 prescaler with period 1.
    applyStimulus(1'b1, 2'd2, 16'h0000);
    applyStimulus(1'b1, 2'd1, 16'd1);
    applyStimulus(1'b1, 2'd0, 16'd0);
    applyStimulus(1'b1, 2'd3, 16'd1);
    applyStimulus(1'b1, 2'd2, 16'h0003);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) applyStimulus(1'b0, 2'd0, 16'd0);
      check($sformatf("t3_tmr%0d", i), tmr, exp_t3[i]);
      check($sformatf("t3_pulse%0d", i), {15'd0, match_pulse}, (i == 8) ? 16'd1 : 16'd0);
    end

    // 1:3 postscaler with period 2, then flag clear racing a flag set.
    applyStimulus(1'b1, 2'd2, 16'h0000);
    applyStimulus(1'b1, 2'd1, 16'd2);
    applyStimulus(1'b1, 2'd0, 16'd0);
    applyStimulus(1'b1, 2'd3, 16'd1);
    applyStimulus(1'b1, 2'd2, 16'h0011);
    for (int i = 1; i < 20; i++) begin
      applyStimulus((i == 10) || (i == 18) || (i == 19), 2'd3, 16'd1);
      check($sformatf("t4_pulse%0d", i), {15'd0, match_pulse}, ((i % 3) == 0) ? 16'd1 : 16'd0);
      check($sformatf("t4_if%0d", i), {15'd0, tmr_if}, ((i == 9) || (i == 18)) ? 16'd1 : 16'd0);
    end

    // Count from above the period wraps through zero without a match.
    applyStimulus(1'b1, 2'd2, 16'h0000);
    applyStimulus(1'b1, 2'd1, 16'd3);
    applyStimulus(1'b1, 2'd2, 16'h0001);
    applyStimulus(1'b1, 2'd0, 16'hFFFE);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) applyStimulus(1'b0, 2'd0, 16'd0);
      check($sformatf("t5_tmr%0d", i), tmr, exp_t5[i]);
      check($sformatf("t5_pulse%0d", i), {15'd0, match_pulse}, (i == 6) ? 16'd1 : 16'd0);
    end

    // Asynchronous reset in the middle of a running count.
    applyStimulus(1'b0, 2'd0, 16'd0);
    @(negedge clk);
    wr_en   = 1'b0;
    rd_addr = 2'd2;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_tmr", tmr, 16'd0);
    check("mid_pr", pr, 16'hFFFF);
    check("mid_if", {15'd0, tmr_if}, 16'd0);
    check("mid_pulse", {15'd0, match_pulse}, 16'd0);
    check("mid_con", rd_data, 16'd0);
    @(posedge clk);
    #1;
    check("mid_hold_tmr", tmr, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();

    // Randomized register traffic against the model.
    applyStimulus(1'b1, 2'd1, 16'd5);
    applyStimulus(1'b1, 2'd2, 16'h0001);
    for (int n = 0; n < 600; n++) begin
      r_we   = ($urandom_range(0, 5) == 0);
      r_addr = 2'($urandom_range(0, 3));
      case (r_addr)
        2'd0: r_data = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 3))
                                                   : 16'($urandom_range(0, 7));
        2'd1: r_data = 16'($urandom_range(0, 7));
        2'd2: r_data = 16'($urandom_range(0, 127)) | 16'($urandom_range(0, 3) != 0);
        default: r_data = 16'($urandom_range(0, 1));
      endcase
      applyStimulus(r_we, r_addr, r_data);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
